// File: rtl/alu_pkg.sv
// Shared ALU/multdiv definitions: datapath width, divider iteration counter
// width and the divider FSM state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_t;

endpackage : alu_pkg

// File: rtl/div_restoring_seq_sub_cla.sv
// Carry-lookahead subtractor: diff = a - b computed as a + ~b + 1, built from
// 8-bit lookahead groups; the top group is narrower when N is not a multiple of 8.
module sub_cla #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  localparam int NG     = (N + 7) / 8;
  localparam int LAST_W = N - (NG - 1) * 8;

  logic [N-1:0]  p_s;
  logic [N-1:0]  g_s;
  logic [N:0]    c_s;
  logic [NG-1:0] grp_g_s;
  logic [NG-1:0] grp_p_s;
  logic [NG:0]   grp_c_s;

  // Bitwise propagate/generate against the inverted subtrahend.
  always_comb begin
    p_s = a_i ^ ~b_i;
    g_s = a_i & ~b_i;
  end

  // Group P/G, lookahead across groups, then carries inside each group.
  always_comb begin
    grp_g_s = '0;
    grp_p_s = '0;
    grp_c_s = '0;
    c_s     = '0;
    for (int j = 0; j < NG; j++) begin
      grp_g_s[j] = 1'b0;
      grp_p_s[j] = 1'b1;
      for (int k = 0; k < ((j == NG - 1) ? LAST_W : 8); k++) begin
        grp_g_s[j] = g_s[j*8+k] | (p_s[j*8+k] & grp_g_s[j]);
        grp_p_s[j] = grp_p_s[j] & p_s[j*8+k];
      end
    end
    grp_c_s[0] = 1'b1;
    for (int j = 0; j < NG; j++) begin
      grp_c_s[j+1] = grp_g_s[j] | (grp_p_s[j] & grp_c_s[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c_s[j*8] = grp_c_s[j];
      for (int k = 0; k < ((j == NG - 1) ? LAST_W : 8) - 1; k++) begin
        c_s[j*8+k+1] = g_s[j*8+k] | (p_s[j*8+k] & c_s[j*8+k]);
      end
    end
    c_s[N] = grp_c_s[NG];
  end

  // A missing carry out of the top bit means a borrow.
  always_comb begin
    diff_o   = p_s ^ c_s[N-1:0];
    borrow_o = ~c_s[N];
  end

endmodule : sub_cla

// File: rtl/div_restoring_seq.sv
// Multicycle signed restoring divider: one quotient bit per clock on magnitudes,
// sign correction afterwards, start/ready handshake and divide-by-zero flag.
module div_restoring_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remout_q, remout_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             b_zero_s;
  logic [WIDTH:0]   part_s;
  logic [WIDTH:0]   diff_s;
  logic             borrow_s;
  logic             take_s;

  // Two's complement negate (~x + 1) when en is set; MIN_INT maps to itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Operand magnitudes and the shifted partial remainder for this step.
  always_comb begin
    abs_a_s  = cond_neg(data_operandA, data_operandA[WIDTH-1]);
    abs_b_s  = cond_neg(data_operandB, data_operandB[WIDTH-1]);
    b_zero_s = (data_operandB == {WIDTH{1'b0}});
    part_s   = {rem_q, quo_q[WIDTH-1]};
  end

  sub_cla #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i      (part_s),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (diff_s),
    .borrow_o (borrow_s)
  );

  // Restore (keep the shifted remainder) unless the trial subtraction is non-negative.
  always_comb begin
    take_s = ~borrow_s & ~diff_s[WIDTH];
  end

  // Next-state and output-register logic; a start in any state (re)launches an op.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    remout_d  = remout_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
    if (ctrl_DIV) begin
      dvs_d     = abs_b_s;
      neg_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      neg_rem_d = data_operandA[WIDTH-1];
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = abs_a_s;
      exc_d     = 1'b0;
      if (b_zero_s) begin
        state_d  = DIV_ST_DONE;
        exc_d    = 1'b1;
        result_d = '0;
        remout_d = '0;
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
      end else begin
        state_d  = DIV_ST_RUN;
        busy_d   = 1'b1;
      end
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          state_d = DIV_ST_IDLE;
        end
        DIV_ST_RUN: begin
          rem_d = take_s ? diff_s[WIDTH-1:0] : part_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], take_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DIV_ST_FIX;
          end else begin
            state_d = DIV_ST_RUN;
          end
        end
        DIV_ST_FIX: begin
          result_d = cond_neg(quo_q, neg_quo_q);
          remout_d = cond_neg(rem_q, neg_rem_q);
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          state_d = DIV_ST_IDLE;
        end
        default: begin
          state_d = DIV_ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DIV_ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      remout_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      remout_q  <= remout_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remout_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule : div_restoring_seq

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq: arithmetic reference model with a
// per-cycle compare, plus directed vectors with literal expectations.
module tb_div_restoring_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clock    = 1'b0;
  logic         reset_n  = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] opa      = '0;
  logic [W-1:0] opb      = '0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] exp_res  = '0;
  logic [W-1:0] exp_rem  = '0;
  logic         exp_exc  = 1'b0;
  logic         exp_rdy  = 1'b0;
  logic         exp_busy = 1'b0;
  bit           pend     = 1'b0;
  int           left     = 0;
  logic [W-1:0] p_res    = '0;
  logic [W-1:0] p_rem    = '0;

  div_restoring_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] m_quo(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (sb == 0) return '0;
    return W'(sa / sb);
  endfunction

  function automatic logic [W-1:0] m_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (sb == 0) return '0;
    return W'(sa % sb);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a start schedules the answer LAT-1 edges later; div-by-0 answers next edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0; left <= 0;
      exp_res <= '0; exp_rem <= '0; exp_exc <= 1'b0; exp_rdy <= 1'b0; exp_busy <= 1'b0;
    end else if (ctrl_DIV) begin
      exp_exc <= 1'b0;
      if (opb == '0) begin
        pend <= 1'b0; exp_rdy <= 1'b1; exp_exc <= 1'b1;
        exp_res <= '0; exp_rem <= '0; exp_busy <= 1'b0;
      end else begin
        pend <= 1'b1; left <= LAT - 1; exp_rdy <= 1'b0; exp_busy <= 1'b1;
        p_res <= m_quo(opa, opb); p_rem <= m_rem(opa, opb);
      end
    end else if (pend) begin
      exp_rdy <= 1'b0;
      if (left == 1) begin
        pend <= 1'b0; exp_rdy <= 1'b1; exp_busy <= 1'b0;
        exp_res <= p_res; exp_rem <= p_rem;
      end else begin
        left <= left - 1;
      end
    end else begin
      exp_rdy <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_result", data_result, exp_res);
      check("cyc_remainder", data_remainder, exp_rem);
      check("cyc_rdy", W'(data_resultRDY), W'(exp_rdy));
      check("cyc_busy", W'(busy), W'(exp_busy));
      if (exp_rdy) check("cyc_exc", W'(data_exception), W'(exp_exc));
    end
    if (data_resultRDY) rdy_cnt++;
  end

  task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_DIV = 1'b1; opa = a; opb = b;
    @(negedge clock);
    ctrl_DIV = 1'b0; opa = $urandom; opb = $urandom;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start_now(a, b);
  endtask

  // n counts cycles after the start cycle: 1 means RDY in cycle T+1.
  task automatic wait_rdy(input int budget, output int n);
    n = 1;
    while (!data_resultRDY && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!data_resultRDY) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_rdy", W'(data_resultRDY), 32'd0);
    check("rst_busy", W'(busy), 32'd0);
    chk_en = 1'b1;
    #2 reset_n = 1'b1;

    start_op(32'd100, 32'd7);
    wait_rdy(60, n);
    check("t1_latency", W'(n), 32'd34);
    check("t1_result", data_result, 32'd14);
    check("t1_rem", data_remainder, 32'd2);
    check("t1_exc", W'(data_exception), 32'd0);

    start_op(32'd100, 32'hFFFF_FFF9);
    repeat (33) @(negedge clock);
    check("t2b_rdy", W'(data_resultRDY), 32'd1);
    check("t2b_result", data_result, 32'hFFFF_FFF2);
    check("t2b_rem", data_remainder, 32'd2);
    start_now(32'hFFFF_FF9C, 32'd7);
    wait_rdy(60, n);
    check("t2a_latency", W'(n), 32'd34);
    check("t2a_result", data_result, 32'hFFFF_FFF2);
    check("t2a_rem", data_remainder, 32'hFFFF_FFFE);

    start_op(32'd5, 32'd0);
    wait_rdy(60, n);
    check("t3_latency", W'(n), 32'd1);
    check("t3_exc", W'(data_exception), 32'd1);
    check("t3_result", data_result, 32'd0);
    check("t3_rem", data_remainder, 32'd0);
    start_op(32'd9, 32'd3);
    check("t3_busy", W'(busy), 32'd1);
    wait_rdy(60, n);
    check("t3b_result", data_result, 32'd3);
    check("t3b_exc", W'(data_exception), 32'd0);

    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(60, n);
    check("t4_result", data_result, 32'h8000_0000);
    check("t4_rem", data_remainder, 32'd0);
    check("t4_exc", W'(data_exception), 32'd0);
    start_op(32'h8000_0000, 32'd1);
    wait_rdy(60, n);
    check("t4b_result", data_result, 32'h8000_0000);

    @(negedge clock);
    r0 = rdy_cnt;
    start_op(32'd1000, 32'd10);
    repeat (8) @(negedge clock);
    start_op(32'd81, 32'd9);
    wait_rdy(60, n);
    check("t5_latency", W'(n), 32'd34);
    check("t5_result", data_result, 32'd9);
    @(negedge clock);
    check("t5_rdy_count", W'(rdy_cnt - r0), 32'd1);

    start_op(32'd50, 32'd5);
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    check("t6_result", data_result, 32'd0);
    check("t6_busy", W'(busy), 32'd0);
    check("t6_rdy", W'(data_resultRDY), 32'd0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    r0 = rdy_cnt;
    repeat (40) @(negedge clock);
    check("t6_no_rdy", W'(rdy_cnt - r0), 32'd0);
    start_op(32'd7, 32'd2);
    wait_rdy(60, n);
    check("t6_result2", data_result, 32'd3);
    check("t6_rem2", data_remainder, 32'd1);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = 32'd0 - 32'($urandom_range(1, 255));
        default: b = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      start_op(a, b);
      wait_rdy(60, n);
      check("rnd_latency", W'(n), (b == 32'd0) ? 32'd1 : 32'd34);
      check("rnd_result", data_result, m_quo(a, b));
      check("rnd_rem", data_remainder, m_rem(a, b));
      check("rnd_exc", W'(data_exception), (b == 32'd0) ? 32'd1 : 32'd0);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_restoring_seq
